// File: rtl/module_kp_mult_core.sv
// module_kp_mult_core: keypad operand entry, shift-add multiply, optional BCD conversion (KP_MULT_BCD_EN)
module module_kp_mult_core #(
  parameter int DIGITS = 3,
  parameter int OP_W = 10,
  parameter logic [3:0] KEY_ENTER = 4'hA,
  parameter logic [3:0] KEY_CLEAR = 4'hC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  output logic [OP_W-1:0]              entry_val,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic [OP_W-1:0]              op_a,
  output logic [OP_W-1:0]              op_b,
  output logic [2:0]                   state_o,
  output logic                         busy,
  output logic                         done,
  output logic                         prod_valid,
`ifdef KP_MULT_BCD_EN
  output logic [8*DIGITS-1:0]          product_bcd,
`endif
  output logic [2*OP_W-1:0]            product
);
  localparam int CNT_W = $clog2(DIGITS+1);
  localparam int IW = $clog2(OP_W+1);
  localparam int PW = 2*OP_W;
  typedef enum logic [2:0] {
    ENT_A = 3'd0,
    ENT_B = 3'd1,
    MUL   = 3'd2,
    BCD   = 3'd3,
    DONE  = 3'd4
  } state_t;
  state_t state, state_nx;
  logic [IW-1:0] i;
  logic is_dig, is_ent, is_clr, has_dig, dig_ok, mul_last, b_bit;
  logic [OP_W-1:0] entry_nx;
  logic [PW-1:0] addend;
  assign is_dig = key_valid && key_code <= 4'd9;
  assign is_ent = key_valid && key_code == KEY_ENTER;
  assign is_clr = key_valid && key_code == KEY_CLEAR;
  assign has_dig = digit_cnt != '0;
  assign dig_ok = is_dig && digit_cnt < CNT_W'(DIGITS);
  assign entry_nx = (entry_val << 3) + (entry_val << 1) + OP_W'(key_code);
  assign mul_last = i == IW'(OP_W);
  assign b_bit = |(op_b & (OP_W'(1) << i));
  assign addend = b_bit ? ({{OP_W{1'b0}}, op_a} << i) : '0;
  assign state_o = state;
`ifdef KP_MULT_BCD_EN
  localparam int BW = 8*DIGITS;
  localparam int JW = $clog2(PW+1);
  logic [PW-1:0] sh;
  logic [BW-1:0] bcd, bcd_adj, bcd_nx;
  logic [JW-1:0] j;
  logic bcd_last;
  assign bcd_last = j == JW'(PW-1);
  assign product_bcd = bcd;
  // double-dabble: add 3 to every nibble above 4, then shift in the next product bit
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 2*DIGITS; k++)
      bcd_adj[4*k+:4] = bcd[4*k+:4] > 4'd4 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
    bcd_nx = BW'({bcd_adj, sh[PW-1]});
  end
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ENT_A;
    else state <= state_nx;
  // next-state logic; CLEAR overrides everything
  always_comb begin
    state_nx = state;
    if (is_clr) state_nx = ENT_A;
    else
      case (state)
        ENT_A: state_nx = is_ent && has_dig ? ENT_B : ENT_A;
        ENT_B: state_nx = is_ent && has_dig ? MUL : ENT_B;
`ifdef KP_MULT_BCD_EN
        MUL:   state_nx = mul_last ? BCD : MUL;
        BCD:   state_nx = bcd_last ? DONE : BCD;
`else
        MUL:   state_nx = mul_last ? DONE : MUL;
`endif
        DONE:  state_nx = is_dig ? ENT_A : DONE;
        default: state_nx = ENT_A;
      endcase
  end
  // datapath: entry accumulation, operand commit, multiply and result flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      entry_val <= '0;
      digit_cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      product <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      prod_valid <= 1'b0;
      i <= '0;
`ifdef KP_MULT_BCD_EN
      sh <= '0;
      bcd <= '0;
      j <= '0;
`endif
    end else if (is_clr) begin
      entry_val <= '0;
      digit_cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      product <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      prod_valid <= 1'b0;
      i <= '0;
`ifdef KP_MULT_BCD_EN
      sh <= '0;
      bcd <= '0;
      j <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ENT_A, ENT_B: begin
          if (dig_ok) begin
            entry_val <= entry_nx;
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
          if (is_ent && has_dig) begin
            entry_val <= '0;
            digit_cnt <= '0;
            if (state == ENT_A) op_a <= entry_val;
            else begin
              op_b <= entry_val;
              product <= '0;
              busy <= 1'b1;
              i <= '0;
            end
          end
        end
        MUL: begin
          if (!mul_last) begin
            product <= product + addend;
            i <= i + IW'(1);
          end else begin
`ifdef KP_MULT_BCD_EN
            sh <= product;
            bcd <= '0;
            j <= '0;
`else
            busy <= 1'b0;
            done <= 1'b1;
            prod_valid <= 1'b1;
`endif
          end
        end
`ifdef KP_MULT_BCD_EN
        BCD: begin
          sh <= sh << 1;
          bcd <= bcd_nx;
          j <= j + JW'(1);
          if (bcd_last) begin
            busy <= 1'b0;
            done <= 1'b1;
            prod_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (is_dig) begin
            op_a <= '0;
            op_b <= '0;
            product <= '0;
            prod_valid <= 1'b0;
            entry_val <= OP_W'(key_code);
            digit_cnt <= CNT_W'(1);
`ifdef KP_MULT_BCD_EN
            bcd <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_module_kp_mult_core.sv
// tb_module_kp_mult_core: directed key-sequence vectors plus latency, abort and reset sequences
module tb_module_kp_mult_core;
  localparam int DIGITS = 3;
  localparam int OP_W = 10;
`ifdef KP_MULT_BCD_EN
  localparam int LAT = 3*OP_W + 1;
`else
  localparam int LAT = OP_W + 1;
`endif
  logic clk = 0, rst = 0, key_valid = 0;
  logic [3:0] key_code = 0;
  logic [OP_W-1:0] entry_val, op_a, op_b;
  logic [1:0] digit_cnt;
  logic [2:0] state_o;
  logic busy, done, prod_valid;
  logic [2*OP_W-1:0] product;
`ifdef KP_MULT_BCD_EN
  logic [23:0] product_bcd;
`endif
  int nvec = 0, nerr = 0;

  module_kp_mult_core #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .entry_val(entry_val), .digit_cnt(digit_cnt), .op_a(op_a), .op_b(op_b),
    .state_o(state_o), .busy(busy), .done(done), .prod_valid(prod_valid),
`ifdef KP_MULT_BCD_EN
    .product_bcd(product_bcd),
`endif
    .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] keys;
    int n;
    int a;
    int b;
    int p;
    int ev;
    int dc;
    int st;
    int pv;
    logic [23:0] bcd;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (vec %0d): got %0d, want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_valid = 1;
    @(negedge clk);
    key_valid = 0;
  endtask

  task automatic wait_idle(input int idx);
    int c;
    c = 0;
    while ((state_o == 3'd2 || state_o == 3'd3) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) chk("wait_idle_timeout", idx, c, 0);
  endtask

  initial begin
    int n, seen;
    logic [47:0] t;
    vt[0] = '{48'h12A34A,     6,  12,  34,    408,   0, 0, 4, 1, 24'h000408};
    vt[1] = '{48'h999A999A,   8, 999, 999, 998001,   0, 0, 4, 1, 24'h998001};
    vt[2] = '{48'h9999,       4,   0,   0,      0, 999, 3, 0, 0, 24'h000000};
    vt[3] = '{48'hAB5A0A,     6,   5,   0,      0,   0, 0, 4, 1, 24'h000000};
    vt[4] = '{48'h12A34A6,    7,   0,   0,      0,   6, 1, 0, 0, 24'h000000};
    vt[5] = '{48'h4F2,        3,   0,   0,      0,  42, 2, 0, 0, 24'h000000};
    vt[6] = '{48'h5AE3,       4,   5,   0,      0,   3, 1, 1, 0, 24'h000000};
    vt[7] = '{48'h1023A1000A,10, 102, 100,  10200,   0, 0, 4, 1, 24'h010200};
    vt[8] = '{48'h12A34AA,    7,  12,  34,    408,   0, 0, 4, 1, 24'h000408};
    vt[9] = '{48'h00A3A,      5,   0,   3,      0,   0, 0, 4, 1, 24'h000000};

    #3;
    chk("rst_state", -1, state_o, 0);
    chk("rst_outputs", -1, {entry_val, digit_cnt, op_a, op_b, busy, done, prod_valid}, 0);
    chk("rst_product", -1, product, 0);
    @(negedge clk);
    rst = 1;

    for (int v = 0; v < 10; v++) begin
      press(4'hC);
      for (int k = 0; k < vt[v].n; k++) begin
        t = vt[v].keys >> (4 * (vt[v].n - 1 - k));
        press(t[3:0]);
        if (state_o == 3'd2 || state_o == 3'd3) wait_idle(v);
      end
      @(negedge clk);
      chk("op_a", v, op_a, vt[v].a);
      chk("op_b", v, op_b, vt[v].b);
      chk("product", v, product, vt[v].p);
      chk("entry_val", v, entry_val, vt[v].ev);
      chk("digit_cnt", v, digit_cnt, vt[v].dc);
      chk("state", v, state_o, vt[v].st);
      chk("prod_valid", v, prod_valid, vt[v].pv);
      chk("busy", v, busy, 0);
`ifdef KP_MULT_BCD_EN
      chk("product_bcd", v, product_bcd, vt[v].bcd);
`endif
    end

    // done latency after the second ENTER, and its one-cycle width
    press(4'hC);
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hA);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk("busy_in_mul", -1, busy, 1);
    end while (!done && n < 200);
    chk("done_latency", -1, n, LAT);
    chk("product_at_done", -1, product, 408);
    @(posedge clk);
    #1;
    chk("done_one_cycle", -1, done, 0);
    chk("prod_valid_held", -1, prod_valid, 1);

    // CLEAR during multiply aborts with no done pulse
    press(4'hC);
    press(4'h7); press(4'hA); press(4'h8); press(4'hA);
    chk("in_mul", -1, state_o, 2);
    @(negedge clk);
    press(4'hC);
    chk("clr_state", -1, state_o, 0);
    chk("clr_outputs", -1, {entry_val, digit_cnt, op_a, op_b, busy, done, prod_valid}, 0);
    chk("clr_product", -1, product, 0);
    seen = 0;
    repeat (3*OP_W + 5) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("clr_no_done", -1, seen, 0);

    // asynchronous reset mid-entry zeroes outputs before any clock edge
    press(4'h1); press(4'h2); press(4'hA); press(4'h3);
    chk("pre_rst_op_a", -1, op_a, 12);
    #2;
    rst = 0;
    #1;
    chk("async_rst_op_a", -1, op_a, 0);
    chk("async_rst_entry", -1, {entry_val, digit_cnt}, 0);
    chk("async_rst_state", -1, state_o, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/module_kp_mult_core.md
Name: module_kp_mult_core

Overview:
- Parametrised keypad calculator core that replaces the fixed two-digit load/operand FSMs and the combinational adder.
- Accepts debounced hex key codes, accumulates up to DIGITS decimal digits per operand and commits operands A and B.
- Runs a sequential shift-add multiply and holds the product for the display stage.
- Sits between the keypad decoder/debouncer and the display driver.

Parameters:
- DIGITS, 3, max decimal digits per operand.
- OP_W, 10, binary operand width; must satisfy 2^OP_W > 10^DIGITS-1.
- KEY_ENTER, 4'hA, key code that commits the current operand.
- KEY_CLEAR, 4'hC, key code that aborts and clears everything.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  4  hex key value
- entry_val  out  OP_W  binary value of operand currently being typed
- digit_cnt  out  $clog2(DIGITS+1)  digits typed in current operand
- op_a  out  OP_W  committed operand A
- op_b  out  OP_W  committed operand B
- state_o  out  3  current FSM state encoding
- busy  out  1  high while multiplying (and converting, if enabled)
- done  out  1  one-cycle pulse when product becomes valid
- prod_valid  out  1  product holds a valid result
- product  out  2*OP_W  op_a*op_b

Behaviour:
- Reset: while rst=0, all outputs are 0 and state=ENT_A (3'd0). Reset is asynchronous, active-low and may abort any state.
- States: ENT_A=0, ENT_B=1, MUL=2, BCD=3 (feature only), DONE=4.
- Digit key (0-9) in ENT_A/ENT_B:
  - if digit_cnt<DIGITS: entry_val <= entry_val*10+key (computed as (v<<3)+(v<<1)+d) and digit_cnt++.
  - if digit_cnt==DIGITS: the key is ignored.
- Non-digit keys other than ENTER/CLEAR are ignored in every state.
- ENTER in ENT_A with digit_cnt>0: op_a<=entry_val, entry_val<=0, digit_cnt<=0, go to ENT_B.
- ENTER in ENT_B with digit_cnt>0: op_b<=entry_val, clear entry, product<=0, busy<=1, go to MUL.
- ENTER with digit_cnt==0 is ignored.
- MUL runs exactly OP_W cycles with internal bit index i=0..OP_W-1, LSB first. Each cycle: if op_b[i], product += op_a<<i.
  - After the cycle with i=OP_W-1: go to DONE, busy<=0, done=1 for one cycle, prod_valid<=1.
  - Latency: ENTER for B sampled at edge t gives done high after edge t+1+OP_W.
- Keys during MUL/BCD: digits and ENTER are ignored.
- CLEAR in any state, including MUL: on the next edge, entry_val, digit_cnt, op_a, op_b and product go to 0; busy, prod_valid and done go to 0; state goes to ENT_A. No done pulse is produced.
- DONE:
  - product, op_a, op_b and prod_valid are held.
  - A digit key clears op_a, op_b, product and prod_valid, enters ENT_A and loads that digit as the first digit (digit_cnt=1).
  - ENTER in DONE is ignored.
- Arithmetic is unsigned. The product width of 2*OP_W cannot overflow; no saturation is applied.
- key_valid is assumed single-cycle. A key held across cycles counts once per pulse.

Optional Feature:
- Macro: KP_MULT_BCD_EN.
- Defined:
  - Adds output product_bcd [8*DIGITS-1:0].
  - After MUL, the FSM enters BCD and performs a sequential double-dabble: one shift per cycle over 2*OP_W cycles, busy held high.
  - done and prod_valid assert only when product_bcd is final, i.e. 2*OP_W extra cycles of latency.
  - CLEAR during BCD aborts as above; product_bcd resets to 0.
- Undefined: no product_bcd port, the BCD state is never entered, and MUL goes directly to DONE.

Test Plan:
- Keys 1,2,A,3,4,A -> op_a=12, op_b=34; done pulses exactly OP_W+1 edges after the second A; product=408; prod_valid=1.
- Keys 9,9,9,A,9,9,9,A -> product=998001 (20'hF3A71); 9,9,9,9 -> digit_cnt=3, entry_val=999.
- A with no digits, then B, then 5,A,0,A -> first A and B ignored; op_a=5, op_b=0, product=0, done pulses.
- 7,A,8,A then C on the third MUL cycle -> next edge: state=ENT_A, all outputs 0, no done pulse; rst low mid-entry -> immediate asynchronous zeroing.
- In DONE after 12*34, key 6 -> prod_valid=0, state=ENT_A, entry_val=6, digit_cnt=1.
- With KP_MULT_BCD_EN, 12*34 -> product_bcd=24'h000408; done arrives 3*OP_W+1 edges after the second A.
